// File: rtl/systolic_ctrl_if.sv
// Controller-to-array bundle: job request in, sequencing strobes and buffer addresses out.
// Latency: none, wires only. The master side is the controller.
// Backpressure: none. The job interface is fire-and-forget, and busy gates new starts.
// Optional perf counter port is present when SYSTOLIC_CTRL_PERF_EN is defined.
interface systolic_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             busy;
  logic             done;
  logic             b_path_en;
  logic             b_en;
  logic [CNT_W-1:0] wgt_rd_addr;
  logic             a_valid;
  logic [CNT_W-1:0] inp_rd_addr;
  logic             out_valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]      perf_cycles;

  modport master (
    input  start, num_vec,
    output busy, done, b_path_en, b_en, wgt_rd_addr, a_valid, inp_rd_addr, out_valid, perf_cycles
  );
  modport slave (
    output start, num_vec,
    input  busy, done, b_path_en, b_en, wgt_rd_addr, a_valid, inp_rd_addr, out_valid, perf_cycles
  );
`else
  modport master (
    input  start, num_vec,
    output busy, done, b_path_en, b_en, wgt_rd_addr, a_valid, inp_rd_addr, out_valid
  );
  modport slave (
    output start, num_vec,
    input  busy, done, b_path_en, b_en, wgt_rd_addr, a_valid, inp_rd_addr, out_valid
  );
`endif
endinterface

// File: rtl/systolic_ctrl.sv
// Systolic array sequencer: weight load, weight latch, input stream, result drain.
// Latency: first out_valid comes OUT_LAT cycles after the first a_valid. All outputs are registered.
// Backpressure: none. A start request is honoured only in IDLE and ignored everywhere else.
// Optional feature: define SYSTOLIC_CTRL_PERF_EN to add the perf_cycles busy-cycle counter.
module systolic_ctrl #(
  parameter int ARRAY_N = 4,
  parameter int CNT_W   = 16,
  parameter int OUT_LAT = 2*ARRAY_N+1
) (
  input  logic              clk,
  input  logic              rst,
  systolic_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LATCH_W, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(ARRAY_N-1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] nv_q;
  // vpipe[k] holds a_valid from k cycles ago. Bit 0 is the live a_valid output.
  logic [OUT_LAT-1:0] vpipe;

  logic             busy_nxt, done_nxt, b_path_en_nxt, b_en_nxt, a_valid_nxt;
  logic [CNT_W-1:0] wgt_addr_nxt, inp_addr_nxt;
  logic             start_acc;

  assign start_acc   = (state == S_IDLE) && bus.start;
  assign bus.a_valid = vpipe[0];

  // State register and the job length captured at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      nv_q  <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) nv_q <= bus.num_vec;
    end
  end

  // Next-state logic. Addresses double as phase counters, so no counter runs past its last index.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.start) state_nxt = S_LOAD_W;
      S_LOAD_W:  if (bus.wgt_rd_addr == W_LAST) state_nxt = S_LATCH_W;
      S_LATCH_W: state_nxt = (nv_q == '0) ? S_DONE : S_STREAM;
      S_STREAM:  if (bus.inp_rd_addr == nv_q - ONE) state_nxt = S_DRAIN;
      // The in-flight pipe is empty once the final out_valid has been registered.
      S_DRAIN:   if (vpipe == '0) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so every strobe lands in a flop aligned with its state.
  always_comb begin
    busy_nxt      = (state_nxt != S_IDLE);
    done_nxt      = (state_nxt == S_DONE);
    b_path_en_nxt = (state_nxt == S_LOAD_W);
    b_en_nxt      = (state_nxt == S_LATCH_W);
    a_valid_nxt   = (state_nxt == S_STREAM);
    wgt_addr_nxt  = bus.wgt_rd_addr;
    inp_addr_nxt  = bus.inp_rd_addr;
    if (state == S_IDLE && state_nxt == S_LOAD_W)
      wgt_addr_nxt = '0;
    else if (state == S_LOAD_W && state_nxt == S_LOAD_W)
      wgt_addr_nxt = bus.wgt_rd_addr + ONE;
    if (state == S_LATCH_W && state_nxt == S_STREAM)
      inp_addr_nxt = '0;
    else if (state == S_STREAM && state_nxt == S_STREAM)
      inp_addr_nxt = bus.inp_rd_addr + ONE;
  end

  // Registered outputs, plus the a_valid delay line that produces out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.b_path_en   <= 1'b0;
      bus.b_en        <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.wgt_rd_addr <= '0;
      bus.inp_rd_addr <= '0;
      vpipe           <= '0;
    end else begin
      bus.busy        <= busy_nxt;
      bus.done        <= done_nxt;
      bus.b_path_en   <= b_path_en_nxt;
      bus.b_en        <= b_en_nxt;
      bus.out_valid   <= vpipe[OUT_LAT-1];
      bus.wgt_rd_addr <= wgt_addr_nxt;
      bus.inp_rd_addr <= inp_addr_nxt;
      vpipe           <= {vpipe[OUT_LAT-2:0], a_valid_nxt};
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  // Busy-cycle counter. It clears on an accepted start and holds between jobs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            bus.perf_cycles <= '0;
    else if (start_acc) bus.perf_cycles <= '0;
    else if (bus.busy)  bus.perf_cycles <= bus.perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with ARRAY_N=4, OUT_LAT=9 and CNT_W=8, so the full-range job stays short.
// Cycle 0 is the cycle where start is driven. Cycle c outputs are read at the c-th following negedge.
module tb_systolic_ctrl;

  localparam int AN = 4;
  localparam int CW = 8;

  logic clk, rst;
  int   checks   = 0;
  int   failures = 0;

  systolic_ctrl_if #(.CNT_W(CW)) bus();
  systolic_ctrl #(.ARRAY_N(AN), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nv;
    int first_a;   // -1 when no a_valid is expected
    int n_a;
    int first_ov;  // -1 when no out_valid is expected
    int n_ov;
    int done_cyc;  // this is also the busy cycle count
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},      bus.busy, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_b_path_en"}, bus.b_path_en, 0);
    chk({tag, "_b_en"},      bus.b_en, 0);
    chk({tag, "_a_valid"},   bus.a_valid, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_wgt_addr"},  bus.wgt_rd_addr, 0);
    chk({tag, "_inp_addr"},  bus.inp_rd_addr, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk({tag, "_perf"},      bus.perf_cycles, 0);
`endif
  endtask

  // Runs one job from a negedge. p1/p2 are extra cycles that pulse start while the job is active.
  task automatic run_job(input vec_t v, input int p1, input int p2);
    int c = 0;
    int n_bp = 0, first_bp = -1, n_be = 0, be_cyc = -1;
    int n_a = 0, first_a = -1, last_a = -1, n_ov = 0, first_ov = -1, last_ov = -1;
    int n_done = 0, done_cyc = -1, n_busy = 0, waddr_bad = 0, iaddr_bad = 0;
    int post_busy = 0, post_done = 0;
    bit fin = 0;
    string t = $sformatf("nv%0d", v.nv);
    bus.start   = 1'b1;
    bus.num_vec = CW'(v.nv);
    while (!fin && c < 2000) begin
      @(negedge clk);
      c++;
      bus.start = (c == p1 || c == p2);
      if (bus.b_path_en) begin
        if (first_bp < 0) first_bp = c;
        if (int'(bus.wgt_rd_addr) != c - first_bp) waddr_bad++;
        n_bp++;
      end
      if (bus.b_en) begin n_be++; be_cyc = c; end
      if (bus.a_valid) begin
        if (first_a < 0) first_a = c;
        if (int'(bus.inp_rd_addr) != c - first_a) iaddr_bad++;
        n_a++; last_a = c;
      end
      if (bus.out_valid) begin
        if (first_ov < 0) first_ov = c;
        n_ov++; last_ov = c;
      end
      if (bus.busy) n_busy++;
      if (bus.done) begin n_done++; done_cyc = c; fin = 1; end
    end
    if (!fin) $display("FAIL %s_timeout: got no done within %0d cycles expected done at %0d", t, c, v.done_cyc);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      post_busy += int'(bus.busy);
      post_done += int'(bus.done);
    end
    chk({t, "_first_bpath"}, first_bp, 1);
    chk({t, "_n_bpath"},     n_bp, AN);
    chk({t, "_wgt_addr_seq"}, waddr_bad, 0);
    chk({t, "_n_b_en"},      n_be, 1);
    chk({t, "_b_en_cyc"},    be_cyc, AN + 1);
    chk({t, "_first_a"},     first_a, v.first_a);
    chk({t, "_n_a"},         n_a, v.n_a);
    chk({t, "_a_gap"},       (n_a > 0) ? last_a - first_a + 1 - n_a : 0, 0);
    chk({t, "_inp_addr_seq"}, iaddr_bad, 0);
    chk({t, "_first_ov"},    first_ov, v.first_ov);
    chk({t, "_n_ov"},        n_ov, v.n_ov);
    chk({t, "_ov_gap"},      (n_ov > 0) ? last_ov - first_ov + 1 - n_ov : 0, 0);
    chk({t, "_done_cyc"},    done_cyc, v.done_cyc);
    chk({t, "_n_done"},      n_done + post_done, 1);
    chk({t, "_n_busy"},      n_busy, v.done_cyc);
    chk({t, "_post_busy"},   post_busy, 0);
    chk({t, "_wgt_hold"},    bus.wgt_rd_addr, AN - 1);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk({t, "_perf"},        bus.perf_cycles, v.done_cyc);
`endif
  endtask

  vec_t tbl[7];

  initial begin
    // Expected values: LOAD_W is cycles 1-4, LATCH_W is cycle 5, STREAM starts at cycle 6,
    // out_valid starts 9 cycles later, and done comes one cycle after the last out_valid.
    tbl[0] = '{nv: 3,   first_a: 6,  n_a: 3,   first_ov: 15, n_ov: 3,   done_cyc: 18};
    tbl[1] = '{nv: 0,   first_a: -1, n_a: 0,   first_ov: -1, n_ov: 0,   done_cyc: 6};
    tbl[2] = '{nv: 1,   first_a: 6,  n_a: 1,   first_ov: 15, n_ov: 1,   done_cyc: 16};
    tbl[3] = '{nv: 9,   first_a: 6,  n_a: 9,   first_ov: 15, n_ov: 9,   done_cyc: 24};
    tbl[4] = '{nv: 10,  first_a: 6,  n_a: 10,  first_ov: 15, n_ov: 10,  done_cyc: 25};
    tbl[5] = '{nv: 20,  first_a: 6,  n_a: 20,  first_ov: 15, n_ov: 20,  done_cyc: 35};
    tbl[6] = '{nv: 255, first_a: 6,  n_a: 255, first_ov: 15, n_ov: 255, done_cyc: 270};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.num_vec = '0;
    #1 rst = 1'b1;
    #2 chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(tbl[i], -1, -1);

`ifdef SYSTOLIC_CTRL_PERF_EN
    // The counter holds after an idle stretch, and the next accepted start clears it.
    repeat (3) @(negedge clk);
    chk("perf_hold_idle", bus.perf_cycles, 270);
    bus.start = 1'b1;
    bus.num_vec = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("perf_clear_on_start", bus.perf_cycles, 0);
    while (!bus.done) @(negedge clk);
    @(negedge clk);
`endif

    // start pulses during STREAM (cycle 7) and in the DONE cycle (18) must both be ignored.
    run_job(tbl[0], 7, 18);
    run_job(tbl[0], -1, -1);

    // Reset in the middle of STREAM clears everything without waiting for a clock edge.
    bus.start = 1'b1;
    bus.num_vec = 8'd5;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_rst_a_valid", bus.a_valid, 1);
    #1 rst = 1'b1;
    #1 chk_reset("midjob_rst");
    @(negedge clk);
    rst = 1'b0;
    run_job(tbl[0], -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
